sw_debounce_sampler: RTL and testbench

- Input conditioning stage that sits directly upstream of the 8-to-3 priority encoder / seven-segment path.
- Takes the raw board switches: 8 data switches plus 1 enable switch.
- Synchronises them to clk, debounces them as one 9-bit vector, and presents clean, glitch-free data/enable to the encoder.
- Also emits a one-cycle change pulse and a wrap-around change counter for display/debug.

---
 rtl/sw_debounce_sampler_if.sv | 31 +++
 rtl/sw_debounce_sampler.sv | 72 +++++++
 tb/tb_sw_debounce_sampler.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sw_debounce_sampler_if.sv
// Switch-side and encoder-side signals of the debounce sampler, bundled for port connection.
// The master drives the raw switches; the slave (the sampler) drives the conditioned outputs.
interface sw_debounce_sampler_if;
  logic [7:0] sw_data;
  logic       sw_en;
  logic [7:0] data_out;
  logic       enable_out;
  logic       changed;
  logic       stable;
  logic [7:0] change_cnt;

  modport master (
    output sw_data,
    output sw_en,
    input  data_out,
    input  enable_out,
    input  changed,
    input  stable,
    input  change_cnt
  );

  modport slave (
    input  sw_data,
    input  sw_en,
    output data_out,
    output enable_out,
    output changed,
    output stable,
    output change_cnt
  );
endinterface

// File: rtl/sw_debounce_sampler.sv
// Synchronises and debounces the 8 data switches plus enable switch as one 9-bit vector,
// committing a new value only after it has held for STABLE_CYCLES consecutive clocks.
module sw_debounce_sampler #(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sw_debounce_sampler_if.slave  sw
);

  localparam int VW = 9;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [VW-1:0]    raw_v;
  logic [VW-1:0]    sync2;
  logic [VW-1:0]    cand_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [VW-1:0]    committed_reg;
  logic             changed_reg;
  logic [7:0]       change_cnt_reg;

  assign raw_v = {sw.sw_en, sw.sw_data};

  // Two-flop synchroniser per switch; nothing else may look at raw_v.
  for (genvar gi = 0; gi < VW; gi++) begin : g_sync
    logic s1_reg;
    logic s2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_reg <= 1'b0;
        s2_reg <= 1'b0;
      end else begin
        s1_reg <= raw_v[gi];
        s2_reg <= s1_reg;
      end
    end

    assign sync2[gi] = s2_reg;
  end

  // Any difference restarts the window for the whole vector; the count saturates at CNT_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_reg       <= '0;
      cnt_reg        <= '0;
      committed_reg  <= '0;
      changed_reg    <= 1'b0;
      change_cnt_reg <= 8'd0;
    end else begin
      changed_reg <= 1'b0;
      if (sync2 != cand_reg) begin
        cand_reg <= sync2;
        cnt_reg  <= '0;
      end else if (cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + 1'b1;
      end else if (cand_reg != committed_reg) begin
        committed_reg  <= cand_reg;
        changed_reg    <= 1'b1;
        change_cnt_reg <= change_cnt_reg + 8'd1;
      end
    end
  end

  assign sw.data_out   = committed_reg[7:0];
  assign sw.enable_out = committed_reg[8];
  assign sw.changed    = changed_reg;
  assign sw.change_cnt = change_cnt_reg;
  assign sw.stable     = (sync2 == cand_reg) && (cand_reg == committed_reg);

endmodule

// File: tb/tb_sw_debounce_sampler.sv
// Randomised and directed bench for sw_debounce_sampler against a sliding-window model
// of the switch history.
module tb_sw_debounce_sampler;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sw_debounce_sampler_if bus ();

  sw_debounce_sampler #(.STABLE_CYCLES(SC), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (bus.slave)
  );

  int err_cnt = 0;
  int chk_cnt = 0;
  int pulse_cnt = 0;

  // Model: history of applied vectors, newest first; index 0 is the most recent edge.
  logic [8:0] vq[$];
  logic [8:0] m_commit;
  logic [7:0] m_cnt;
  logic       m_changed;
  logic       m_stable;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    vq.delete();
    for (int i = 0; i < SC + 2; i++) vq.push_back(9'd0);
    m_commit  = 9'd0;
    m_cnt     = 8'd0;
    m_changed = 1'b0;
    m_stable  = 1'b1;
  endtask

  // A value commits once the synchronised copies of it span SC+1 consecutive edges.
  task automatic model_edge(input logic [8:0] cur);
    bit same;
    same = 1'b1;
    for (int i = 2; i <= SC + 1; i++) if (vq[i] != vq[1]) same = 1'b0;
    m_changed = 1'b0;
    if (same && vq[1] != m_commit) begin
      m_commit  = vq[1];
      m_cnt     = m_cnt + 8'd1;
      m_changed = 1'b1;
    end
    vq.push_front(cur);
    void'(vq.pop_back());
    m_stable = (vq[1] == vq[2]) && (vq[2] == m_commit);
  endtask

  task automatic compare_all();
    check("data_out",   {24'd0, bus.data_out},   {24'd0, m_commit[7:0]});
    check("enable_out", {31'd0, bus.enable_out}, {31'd0, m_commit[8]});
    check("changed",    {31'd0, bus.changed},    {31'd0, m_changed});
    check("change_cnt", {24'd0, bus.change_cnt}, {24'd0, m_cnt});
    check("stable",     {31'd0, bus.stable},     {31'd0, m_stable});
  endtask

  task automatic set_v(input logic [8:0] v);
    bus.sw_en   = v[8];
    bus.sw_data = v[7:0];
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge({bus.sw_en, bus.sw_data});
    #1;
    if (bus.changed === 1'b1) pulse_cnt++;
    compare_all();
  endtask

  task automatic run_until_commit(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.changed !== 1'b1 && n < limit);
    if (bus.changed !== 1'b1) check("commit_timeout", {31'd0, bus.changed}, 32'd1);
  endtask

  initial begin
    int n;
    int hold;
    logic [8:0] v;

    // Reset with random switches
    model_reset();
    set_v(9'($urandom));
    #2;
    compare_all();
    repeat (3) begin
      set_v(9'($urandom));
      step();
    end
    check("rst_stable", {31'd0, bus.stable}, 32'd1);
    set_v(9'd0);
    rst_n = 1'b1;
    pulse_cnt = 0;
    repeat (20) step();
    check("rst_no_pulse", pulse_cnt, 0);

    // Clean change
    set_v({1'b1, 8'h80});
    run_until_commit(20, n);
    check("clean_latency", n, 7);
    check("clean_data", {24'd0, bus.data_out}, 32'h80);
    check("clean_en", {31'd0, bus.enable_out}, 32'd1);
    check("clean_cnt", {24'd0, bus.change_cnt}, 32'd1);
    repeat (5) step();
    $display("clean change: latency=%0d data=%0h", n, bus.data_out);

    // Bounce on sw_data[3], then settle on 8'h08
    pulse_cnt = 0;
    for (int t = 0; t < 10; t++) begin
      set_v({1'b0, (t % 2 == 0) ? 8'h08 : 8'h00});
      step();
      step();
    end
    check("bounce_no_commit", pulse_cnt, 0);
    set_v({1'b0, 8'h08});
    run_until_commit(20, n);
    check("bounce_latency", n, 7);
    repeat (8) step();
    check("bounce_pulses", pulse_cnt, 1);
    check("bounce_data", {24'd0, bus.data_out}, 32'h08);
    $display("bounce: latency=%0d pulses=%0d", n, pulse_cnt);

    // Glitch that returns to the committed value
    pulse_cnt = 0;
    set_v({1'b0, 8'h0C});
    repeat (3) step();
    set_v({1'b0, 8'h08});
    repeat (20) step();
    check("glitch_pulses", pulse_cnt, 0);
    check("glitch_data", {24'd0, bus.data_out}, 32'h08);
    check("glitch_cnt", {24'd0, bus.change_cnt}, 32'd2);
    $display("glitch back: data=%0h cnt=%0d", bus.data_out, bus.change_cnt);

    // Reset in the middle of a pending window
    pulse_cnt = 0;
    set_v({1'b0, 8'hFF});
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("midrst_data", {24'd0, bus.data_out}, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    run_until_commit(20, n);
    check("midrst_latency", n, 7);
    check("midrst_data_after", {24'd0, bus.data_out}, 32'hFF);
    check("midrst_cnt", {24'd0, bus.change_cnt}, 32'd1);
    $display("reset mid-window: latency after release=%0d", n);

    // Random segments: new values, single-bit flips, glitches back, holds
    for (int s = 0; s < 80; s++) begin
      case ($urandom_range(0, 3))
        0: v = 9'($urandom);
        1: v = {bus.sw_en, bus.sw_data} ^ (9'd1 << $urandom_range(0, 8));
        2: v = m_commit;
        default: v = {bus.sw_en, bus.sw_data};
      endcase
      set_v(v);
      hold = $urandom_range(1, 8);
      repeat (hold) step();
      $display("random seg %0d: v=%0h hold=%0d out=%0h", s, v, hold, {bus.enable_out, bus.data_out});
    end

    // 256 alternating commits wrap change_cnt
    rst_n = 1'b0;
    model_reset();
    set_v(9'd0);
    step();
    rst_n = 1'b1;
    pulse_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      set_v({1'b0, (i % 2 == 0) ? 8'h01 : 8'h02});
      run_until_commit(20, n);
      check("wrap_latency", n, 7);
    end
    repeat (3) step();
    check("wrap_pulses", pulse_cnt, 256);
    check("wrap_cnt", {24'd0, bus.change_cnt}, 32'd0);
    $display("wrap: pulses=%0d change_cnt=%0d", pulse_cnt, bus.change_cnt);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
